posit_decode_pipe: RTL

Pipelined posit<N,es> unpacker with valid/ready handshake on both sides. It takes a packed posit word (the format produced by the team's posit arithmetic units) and splits it into sign, combined scale (regime·2^es + exponent), left-aligned fraction and zero/NaR flags. It sits at the consumer end of posit datapaths and feeds fixed-point, float-conversion and debug logic that need decoded fields.

---
 rtl/posit_decode_pipe.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: two-stage posit<N,es> unpacker with valid/ready on both sides.
// Outputs are the sign, the combined scale k*2^es + e, the MSB-aligned fraction and the zero/NaR flags.
// Stage 1 takes the magnitude and measures the regime run. Stage 2 shifts out the regime,
// then forms the exponent, fraction and scale into the output registers.
// Optional feature: define POSIT_DEC_SKID_EN to put a 2-entry skid buffer at the input.
// in_ready then comes straight from a flop, latency becomes 3 and capacity becomes 4 words.
module posit_decode_pipe #(
    parameter int N  = 16,
    parameter int es = 3,
    localparam int Bs = $clog2(N),
    localparam int SW = Bs + es + 1,
    localparam int FW = N - es - 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic [SW-1:0] out_scale,
    output logic [FW-1:0] out_frac,
    output logic          out_zero,
    output logic          out_nar
);

    // handshake between stages
    logic          s2_free_s;
    logic          s1_open_s;
    logic          src_valid_s;
    logic [N-1:0]  src_data_s;
    logic          src_take_s;

    // stage 1 state
    logic          s1_valid_r;
    logic          s1_sign_r;
    logic          s1_zero_r;
    logic          s1_nar_r;
    logic          s1_rc_r;
    logic [N-1:0]  s1_mag_r;
    logic [Bs-1:0] s1_run_r;

    // stage 1 combinational decode
    logic [N-1:0]  mag_s;
    logic          rc_s;
    logic [Bs-1:0] run_s;
    logic          zero_s;
    logic          nar_s;

    // stage 2 combinational decode
    logic [Bs:0]   shamt_s;
    logic [N-1:0]  shifted_s;
    logic [es-1:0] exp_s;
    logic [FW-1:0] frac_s;
    logic [SW-1:0] run_ext_s;
    logic [SW-1:0] k_s;
    logic [SW-1:0] scale_s;

    assign s2_free_s  = !out_valid || out_ready;
    assign s1_open_s  = !s1_valid_r || s2_free_s;
    assign src_take_s = src_valid_s && s1_open_s;

`ifdef POSIT_DEC_SKID_EN
    logic [N-1:0] skid_mem_r [2];
    logic         skid_wr_r;
    logic         skid_rd_r;
    logic [1:0]   skid_cnt_r;
    logic [1:0]   skid_cnt_nxt_s;
    logic         skid_rdy_r;
    logic         skid_push_s;

    assign skid_push_s = in_valid && skid_rdy_r;
    assign src_valid_s = (skid_cnt_r != 2'd0);
    assign src_data_s  = skid_mem_r[skid_rd_r];
    assign in_ready    = skid_rdy_r;

    // next occupancy of the skid buffer
    always_comb begin
        skid_cnt_nxt_s = skid_cnt_r + {1'b0, skid_push_s} - {1'b0, src_take_s};
    end

    // skid buffer storage, pointers and registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_mem_r[0] <= {N{1'b0}};
            skid_mem_r[1] <= {N{1'b0}};
            skid_wr_r     <= 1'b0;
            skid_rd_r     <= 1'b0;
            skid_cnt_r    <= 2'd0;
            skid_rdy_r    <= 1'b1;
        end else begin
            if (skid_push_s) begin
                skid_mem_r[skid_wr_r] <= in_data;
                skid_wr_r             <= ~skid_wr_r;
            end
            if (src_take_s) begin
                skid_rd_r <= ~skid_rd_r;
            end
            skid_cnt_r <= skid_cnt_nxt_s;
            skid_rdy_r <= (skid_cnt_nxt_s != 2'd2);
        end
    end
`else
    assign src_valid_s = in_valid;
    assign src_data_s  = in_data;
    assign in_ready    = s1_open_s;
`endif

    // magnitude, special-value flags and regime run length of the incoming word
    always_comb begin
        logic run_done;
        zero_s   = (src_data_s == {N{1'b0}});
        nar_s    = (src_data_s == {1'b1, {(N-1){1'b0}}});
        if (src_data_s[N-1]) begin
            mag_s = (~src_data_s) + {{(N-1){1'b0}}, 1'b1};
        end else begin
            mag_s = src_data_s;
        end
        rc_s     = mag_s[N-2];
        run_s    = {Bs{1'b0}};
        run_done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!run_done && (mag_s[i] == rc_s)) begin
                run_s = run_s + Bs'(1);
            end else begin
                run_done = 1'b1;
            end
        end
    end

    // stage 1 register: loads whenever it is empty or its word moves on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_zero_r  <= 1'b0;
            s1_nar_r   <= 1'b0;
            s1_rc_r    <= 1'b0;
            s1_mag_r   <= {N{1'b0}};
            s1_run_r   <= {Bs{1'b0}};
        end else if (s1_open_s) begin
            s1_valid_r <= src_valid_s;
            if (src_valid_s) begin
                s1_sign_r <= src_data_s[N-1];
                s1_zero_r <= zero_s;
                s1_nar_r  <= nar_s;
                s1_rc_r   <= rc_s;
                s1_mag_r  <= mag_s;
                s1_run_r  <= run_s;
            end
        end
    end

    // strip sign, regime run and terminator, then form exponent, fraction and scale
    always_comb begin
        shamt_s   = {1'b0, s1_run_r} + (Bs+1)'(2);
        shifted_s = s1_mag_r << shamt_s;
        exp_s     = shifted_s[N-1 -: es];
        frac_s    = shifted_s[N-1-es -: FW];
        run_ext_s = SW'(s1_run_r);
        if (s1_rc_r) begin
            k_s = run_ext_s - SW'(1);
        end else begin
            k_s = SW'(0) - run_ext_s;
        end
        scale_s = (k_s << es) + SW'(exp_s);
    end

    // output register: holds while the consumer stalls, zeroes fields for 0 and NaR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_scale <= {SW{1'b0}};
            out_frac  <= {FW{1'b0}};
            out_zero  <= 1'b0;
            out_nar   <= 1'b0;
        end else if (s2_free_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_zero <= s1_zero_r;
                out_nar  <= s1_nar_r;
                if (s1_zero_r || s1_nar_r) begin
                    out_sign  <= 1'b0;
                    out_scale <= {SW{1'b0}};
                    out_frac  <= {FW{1'b0}};
                end else begin
                    out_sign  <= s1_sign_r;
                    out_scale <= scale_s;
                    out_frac  <= frac_s;
                end
            end
        end
    end

endmodule
